// File: rtl/la_rrarb.sv
// la_rrarb: round-robin arbiter with registered, transaction-locked grants.
// Define LA_RRARB_TIMEOUT_EN to force release of an owner that stalls TIMEOUT cycles.
`timescale 1ns/1ps

module la_rrarb #(
    parameter int  N       = 3,
    parameter int  TIMEOUT = 16,
    parameter      PROP    = "DEFAULT",
    localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          last,
    input  logic          en,
    input  logic          ready,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic          fire,
    output logic [OW-1:0] owner
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;

    logic          win_vld;
    logic [OW-1:0] win_idx;
    logic [N-1:0]  win_oh;
    logic          own_req;
    logic          tmo;
    logic          rel;

    // Scan ptr, ptr+1, ... wrapping at N so indices >= N are never formed.
    always_comb begin
        int            j;
        logic [OW-1:0] idx;
        win_vld = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end
            idx = OW'(j);
            if (!win_vld && req[idx]) begin
                win_vld     = 1'b1;
                win_idx     = idx;
                win_oh[idx] = 1'b1;
            end
        end
    end

    assign own_req = |(gnt_q & req);
    assign fire    = own_req & en & ready;

`ifdef LA_RRARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tmo = (state_q == S_GRANT) && !fire &&
                 (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_GRANT && !rel && !fire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    assign rel = (state_q == S_GRANT) &&
                 ((fire && last) || !own_req || tmo);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (en && win_vld) begin
                    state_d = S_GRANT;
                    gnt_d   = win_oh;
                    busy_d  = 1'b1;
                    owner_d = win_idx;
                end
            end
            S_GRANT: begin
                if (rel) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    owner_d = '0;
                    if (owner_q == OW'(N - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = owner_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = busy_q;
    assign owner = owner_q;

    // PROP is a pass-through tag; TIMEOUT only matters in the timeout build.
    logic unused_cfg;
    assign unused_cfg = ^{PROP, TIMEOUT};

endmodule

// File: tb/tb_la_rrarb.sv
// tb_la_rrarb: directed vectors for la_rrarb (N=3, TIMEOUT=4).
// Per-cycle checks plus a beat scoreboard popped on every fire.
`timescale 1ns/1ps

module tb_la_rrarb;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic       last;
    logic       en;
    logic       ready;
    logic [2:0] gnt;
    logic       busy;
    logic       fire;
    logic [1:0] owner;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_q[$];
    logic [2:0] mon_e;

    always #5 clk = ~clk;

    la_rrarb #(
        .N       (3),
        .TIMEOUT (4),
        .PROP    ("DEFAULT")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .last  (last),
        .en    (en),
        .ready (ready),
        .gnt   (gnt),
        .busy  (busy),
        .fire  (fire),
        .owner (owner)
    );

    function automatic logic [1:0] idx_of(input logic [2:0] g);
        if (g[1]) return 2'd1;
        if (g[2]) return 2'd2;
        return 2'd0;
    endfunction

    // Beat scoreboard: every fire must match the next expected owner.
    always @(negedge clk) begin
        total++;
        if (!$onehot0(gnt)) begin
            bad++;
            $display("FAIL onehot: gnt=%b", gnt);
        end
        if (fire === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat: unexpected fire gnt=%b", gnt);
            end else begin
                mon_e = exp_q.pop_front();
                if (gnt !== mon_e || owner !== idx_of(mon_e)) begin
                    bad++;
                    $display("FAIL beat: gnt=%b owner=%0d want gnt=%b owner=%0d",
                             gnt, owner, mon_e, idx_of(mon_e));
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [2:0] eg,
                       input logic eb, input logic ef);
        total++;
        if (gnt !== eg || busy !== eb || fire !== ef ||
            owner !== idx_of(eg)) begin
            bad++;
            $display("FAIL %s: gnt=%b busy=%b fire=%b owner=%0d want gnt=%b busy=%b fire=%b owner=%0d",
                     nm, gnt, busy, fire, owner, eg, eb, ef, idx_of(eg));
        end
    endtask

    task automatic cyc(input string nm, input logic [2:0] r,
                       input logic l, input logic e, input logic rd,
                       input logic [2:0] eg, input logic eb,
                       input logic ef);
        req   = r;
        last  = l;
        en    = e;
        ready = rd;
        if (ef) exp_q.push_back(eg);
        @(negedge clk);
        chk(nm, eg, eb, ef);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = 3'b111;
        last  = 1'b1;
        en    = 1'b1;
        ready = 1'b1;
        cyc("rst0", 3'b111, 1, 1, 1, 3'b000, 0, 0);
        cyc("rst1", 3'b111, 1, 1, 1, 3'b000, 0, 0);
        reset = 1'b0;

        cyc("t1a", 3'b111, 1, 1, 1, 3'b000, 0, 0);
        cyc("t1b", 3'b111, 1, 1, 1, 3'b001, 1, 1);
        cyc("t1c", 3'b111, 1, 1, 1, 3'b000, 0, 0);
        cyc("t1d", 3'b111, 1, 1, 1, 3'b010, 1, 1);
        cyc("t1e", 3'b111, 1, 1, 1, 3'b000, 0, 0);
        cyc("t1f", 3'b111, 1, 1, 1, 3'b100, 1, 1);
        cyc("t1g", 3'b111, 1, 1, 1, 3'b000, 0, 0);
        cyc("t1h", 3'b111, 1, 1, 1, 3'b001, 1, 1);

        cyc("t2a", 3'b010, 0, 1, 1, 3'b000, 0, 0);
        cyc("t2b", 3'b010, 0, 1, 1, 3'b010, 1, 1);
        cyc("t2c", 3'b010, 0, 1, 0, 3'b010, 1, 0);
        cyc("t2d", 3'b010, 0, 1, 1, 3'b010, 1, 1);
        cyc("t2e", 3'b010, 1, 1, 1, 3'b010, 1, 1);
        cyc("t2p", 3'b101, 0, 1, 1, 3'b000, 0, 0);
        cyc("t2q", 3'b101, 1, 1, 1, 3'b100, 1, 1);

        cyc("t3a", 3'b001, 0, 1, 1, 3'b000, 0, 0);
        cyc("t3b", 3'b001, 0, 0, 1, 3'b001, 1, 0);
        cyc("t3c", 3'b001, 0, 0, 1, 3'b001, 1, 0);
        cyc("t3d", 3'b001, 0, 0, 1, 3'b001, 1, 0);
        cyc("t3e", 3'b001, 0, 1, 1, 3'b001, 1, 1);
        cyc("t3f", 3'b001, 1, 1, 1, 3'b001, 1, 1);

        cyc("t4a", 3'b100, 0, 1, 1, 3'b000, 0, 0);
        cyc("t4b", 3'b100, 0, 1, 0, 3'b100, 1, 0);
        cyc("t4c", 3'b011, 0, 1, 1, 3'b100, 1, 0);
        cyc("t4d", 3'b011, 0, 1, 1, 3'b000, 0, 0);
        cyc("t4e", 3'b011, 1, 1, 1, 3'b001, 1, 1);

        cyc("t5a", 3'b100, 0, 1, 1, 3'b000, 0, 0);
        cyc("t5b", 3'b100, 0, 1, 1, 3'b100, 1, 1);
        reset = 1'b1;
        cyc("t5c", 3'b100, 0, 1, 0, 3'b100, 1, 0);
        reset = 1'b0;
        cyc("t5d", 3'b100, 0, 1, 1, 3'b000, 0, 0);
        cyc("t5e", 3'b100, 1, 1, 1, 3'b100, 1, 1);

        cyc("t6a", 3'b010, 0, 1, 0, 3'b000, 0, 0);
`ifdef LA_RRARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            cyc("t6hold", 3'b011, 0, 1, 0, 3'b010, 1, 0);
        end
        cyc("t6rel", 3'b011, 0, 1, 0, 3'b000, 0, 0);
        cyc("t6nxt", 3'b011, 1, 1, 1, 3'b001, 1, 1);
`else
        for (int i = 0; i < 100; i++) begin
            cyc("t6hold", 3'b011, 0, 1, 0, 3'b010, 1, 0);
        end
        cyc("t6drop", 3'b001, 0, 1, 0, 3'b010, 1, 0);
        cyc("t6idle", 3'b000, 0, 1, 1, 3'b000, 0, 0);
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover beats: have=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
